stack_controller: RTL and testbench
===================================

// Module: stack_controller
// PURPOSE
//   Sequences the stack pointer and stack memory for the CPU core. Accepts PUSH, POP,
//   PEEK and LOAD requests over a valid/ready handshake and owns the SP register.
//   Bounds-checks every operation against the stack window, drives the memory port,
//   and returns one response per accepted request.
//   Sits between the instruction sequencer and the data-memory arbiter.
// PARAMETERS
//   ADDR_W       16        width of SP and mem_addr
//   DATA_W       16        width of stack words
//   STACK_BASE   16'h2800  lowest stack address; SP reset value (stack empty)
//   STACK_LIMIT  16'h3200  SP value when the stack is full (exclusive upper bound)
// PORTS
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       controller can accept a request
//   req_op     in   2       00 PUSH, 01 POP, 10 PEEK, 11 LOAD
//   req_data   in   DATA_W  PUSH data, or new SP for LOAD
//   rsp_valid  out  1       one-cycle response pulse
//   rsp_data   out  DATA_W  POP/PEEK read data (0 for PUSH/LOAD/errors)
//   rsp_err    out  1       qualified by rsp_valid: request rejected, no state change
//   mem_req    out  1       memory access request, held until mem_ack
//   mem_we     out  1       1 = write, 0 = read
//   mem_addr   out  ADDR_W  stack memory address
//   mem_wdata  out  DATA_W  write data
//   mem_rdata  in   DATA_W  read data, valid in the mem_ack cycle
//   mem_ack    in   1       memory completion, sampled only while mem_req=1
//   sp         out  ADDR_W  current stack pointer (next free slot; grows upward)
//   err_count  out  8       saturating count of rejected requests
// BEHAVIOUR
// - Reset (reset=0, takes effect immediately):
//   - state=IDLE, sp=STACK_BASE, err_count=0.
//   - rsp_valid, rsp_err, rsp_data, mem_req, mem_we, mem_addr, mem_wdata all 0.
//   - req_ready forced to 0 while reset=0.
//   - Reset mid-access drops mem_req at once and abandons the operation (no SP update).
// - FSM states:
//   - IDLE: req_ready=1; handshake when req_valid & req_ready on a rising edge.
//     Op and data are latched at handshake.
//   - MEM: mem_req=1; mem_addr, mem_we and mem_wdata are stable until mem_ack.
//   - RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_valid has no backpressure.
// - Transitions out of IDLE on handshake:
//   - PUSH with sp==STACK_LIMIT -> RESP, error.
//   - POP or PEEK with sp==STACK_BASE -> RESP, error.
//   - LOAD -> RESP. If STACK_BASE <= req_data <= STACK_LIMIT, then sp<=req_data;
//     otherwise error with sp unchanged.
//   - Any other PUSH/POP/PEEK -> MEM. No memory access occurs on any error.
// - MEM accesses:
//   - PUSH: mem_we=1, mem_addr=sp, mem_wdata=latched data.
//   - POP/PEEK: mem_we=0, mem_addr=sp-1.
// - On mem_ack in MEM:
//   - PUSH: sp<=sp+1.
//   - POP: sp<=sp-1, rsp_data<=mem_rdata.
//   - PEEK: rsp_data<=mem_rdata, sp unchanged.
//   - Then go to RESP.
// - Latency: handshake at edge N; mem_req high from N+1; ack at edge N+1+k;
//   rsp_valid in cycle N+2+k. Error and LOAD responses arrive in cycle N+1.
// - err_count increments in the cycle rsp_err is asserted and saturates at 8'hFF.
// - SP arithmetic is ADDR_W-bit. Wrap is impossible because of the bounds checks.
// - One request is outstanding at a time. A new request is accepted in the IDLE cycle
//   following RESP.
// TESTING
//   T1 reset low mid-cycle -> sp=2800, mem_req=0, rsp_valid=0, req_ready=0;
//      release -> req_ready=1
//   T2 PUSH ABCD, mem_ack 2 cycles late -> mem_req held 3 cycles, addr=2800, we=1,
//      wdata=ABCD; sp=2801; rsp_err=0
//   T3 POP with mem_rdata=ABCD -> addr=2800, we=0; rsp_data=ABCD; sp=2800;
//      second POP -> rsp_err=1, no mem_req, err_count=1
//   T4 LOAD 31FF, PUSH -> sp=3200; PUSH -> rsp_err=1, sp=3200;
//      LOAD 3300 -> rsp_err=1, sp=3200
//   T5 PEEK at sp=3200 -> addr=31FF, rsp_data=mem_rdata, sp stays 3200
//   T6 reset asserted while in MEM awaiting ack -> mem_req=0 immediately, sp=2800;
//      late mem_ack ignored

Source files
------------

// File: rtl/stack_controller.sv
// Stack controller: owns SP, bounds-checks PUSH/POP/PEEK/LOAD and sequences the stack memory port.
// Latency: error/LOAD response in the cycle after handshake; memory ops respond 2+k cycles after handshake (k = ack wait).
// Backpressure: req_ready_o only in IDLE (one request outstanding); mem_req_o held until mem_ack_i; rsp_valid_o is never stalled.
//
// Ports: clk_i/reset_ni (async active-low), req_* request handshake (op 00 PUSH, 01 POP, 10 PEEK, 11 LOAD),
//        rsp_* one-cycle response pulse, mem_* stack memory port, sp_o stack pointer, err_count_o saturating reject count.
module stack_controller #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] STACK_BASE  = 16'h2800,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h3200
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [7:0]        err_count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_MEM, ST_RESP} state_e;
  typedef enum logic [1:0] {OP_PUSH = 2'b00, OP_POP = 2'b01, OP_PEEK = 2'b10, OP_LOAD = 2'b11} op_e;

  state_e              state_q;
  op_e                 op_q;
  logic [ADDR_W-1:0]   sp_q;
  logic [7:0]          err_count_q;
  logic                rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  op_e                 req_op;
  logic [ADDR_W-1:0]   load_sp;
  logic                reject;
  logic [7:0]          err_count_d;

  assign req_op  = op_e'(req_op_i);
  // LOAD data is interpreted as an ADDR_W-bit stack address.
  assign load_sp = ADDR_W'(req_data_i);

  // Bounds check of the request being offered, against the current SP.
  always_comb begin
    reject = 1'b0;
    case (req_op)
      OP_PUSH: reject = (sp_q == STACK_LIMIT);
      OP_POP,
      OP_PEEK: reject = (sp_q == STACK_BASE);
      OP_LOAD: reject = (load_sp < STACK_BASE) || (load_sp > STACK_LIMIT);
      default: reject = 1'b0;
    endcase
  end

  assign err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      sp_q        <= STACK_BASE;
      err_count_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            op_q       <= req_op;
            rsp_data_q <= '0;
            if (reject) begin
              // Rejected requests never touch memory or SP.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              err_count_q <= err_count_d;
            end else if (req_op == OP_LOAD) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              sp_q        <= load_sp;
            end else begin
              state_q     <= ST_MEM;
              mem_req_q   <= 1'b1;
              mem_we_q    <= (req_op == OP_PUSH);
              // SP points at the next free slot: PUSH writes at SP, reads hit the top at SP-1.
              mem_addr_q  <= (req_op == OP_PUSH) ? sp_q : sp_q - ADDR_W'(1);
              mem_wdata_q <= (req_op == OP_PUSH) ? req_data_i : '0;
            end
          end
        end
        ST_MEM: begin
          if (mem_ack_i) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            case (op_q)
              OP_PUSH: sp_q <= sp_q + ADDR_W'(1);
              OP_POP: begin
                sp_q       <= sp_q - ADDR_W'(1);
                rsp_data_q <= mem_rdata_i;
              end
              OP_PEEK: rsp_data_q <= mem_rdata_i;
              default: ;
            endcase
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so no handshake can be offered while reset is held.
  assign req_ready_o = (state_q == ST_IDLE) && reset_ni;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign sp_o        = sp_q;
  assign err_count_o = err_count_q;

endmodule

// File: tb/tb_stack_controller.sv
// Testbench for stack_controller: directed vector table, hand-written reset corner cases,
// and randomized requests checked against a behavioural stack model.
// The bench also plays the stack memory, answering after a chosen number of wait cycles.
module tb_stack_controller;

  localparam logic [1:0] PUSH = 2'd0, POP = 2'd1, PEEK = 2'd2, LOAD = 2'd3;
  localparam int BASE  = 'h2800;
  localparam int LIMIT = 'h3200;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'd0;
  logic [15:0] req_data_i = 16'd0;
  logic        rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic [15:0] mem_rdata_i = 16'd0;
  logic        mem_ack_i = 1'b0;
  logic [15:0] sp_o;
  logic [7:0]  err_count_o;

  stack_controller dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .sp_o(sp_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bench-side memory (what the DUT actually talks to) and the model's own view of it.
  logic [15:0] mem_arr [int];
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] mem_rd(input int a);
    return mem_arr.exists(a) ? mem_arr[a] : 16'(a ^ 'hC3A5);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'(a ^ 'hC3A5);
  endfunction

  // One request from an IDLE negedge to the IDLE negedge after its response.
  task automatic txn(input logic [1:0] op, input logic [15:0] d, input int dly,
                     output logic e, output logic [15:0] rd, output int mcyc,
                     output logic [15:0] maddr, output logic mwe, output logic [15:0] mwd,
                     output int lat);
    bit stable = 1'b1;
    bit done = 1'b0;
    e = 1'b0; rd = '0; mcyc = 0; maddr = '0; mwe = 1'b0; mwd = '0; lat = 0;
    check("ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_op_i = op; req_data_i = d;
    @(posedge clk_i);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = 16'($urandom);
      lat++;
      if (rsp_valid_o) begin
        e = rsp_err_o; rd = rsp_data_o; done = 1'b1;
      end else if (mem_req_o) begin
        if (mcyc == 0) begin
          maddr = mem_addr_o; mwe = mem_we_o; mwd = mem_wdata_o;
        end else if (maddr !== mem_addr_o || mwe !== mem_we_o || mwd !== mem_wdata_o) begin
          stable = 1'b0;
        end
        mcyc++;
        if (mcyc > dly) begin
          mem_ack_i = 1'b1;
          if (mem_we_o) mem_arr[int'(mem_addr_o)] = mem_wdata_o;
          else mem_rdata_i = mem_rd(int'(mem_addr_o));
        end
      end
    end
    check("rsp_timeout", 32'(done), 32'd1);
    check("mem_stable", 32'(stable), 32'd1);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    check("rsp_one_cycle", 32'(rsp_valid_o), 32'd0);
    check("ready_after_rsp", 32'(req_ready_o), 32'd1);
  endtask

  // ---------------- behavioural model ----------------
  int ref_sp = BASE;
  int ref_errs = 0;

  task automatic run_model(input logic [1:0] op, input logic [15:0] d, input int dly);
    bit e_err = 1'b0;
    bit e_mem = 1'b0;
    logic [15:0] e_data = '0, e_addr = '0, e_wd = '0;
    logic e_we = 1'b0;
    logic g_err, g_we;
    logic [15:0] g_data, g_addr, g_wd;
    int g_mcyc, g_lat;
    case (op)
      PUSH: if (ref_sp == LIMIT) e_err = 1'b1;
            else begin
              e_mem = 1'b1; e_addr = 16'(ref_sp); e_we = 1'b1; e_wd = d;
              ref_mem[ref_sp] = d; ref_sp = ref_sp + 1;
            end
      POP:  if (ref_sp == BASE) e_err = 1'b1;
            else begin
              e_mem = 1'b1; e_addr = 16'(ref_sp - 1); e_data = ref_rd(ref_sp - 1);
              ref_sp = ref_sp - 1;
            end
      PEEK: if (ref_sp == BASE) e_err = 1'b1;
            else begin
              e_mem = 1'b1; e_addr = 16'(ref_sp - 1); e_data = ref_rd(ref_sp - 1);
            end
      default: if (int'(d) < BASE || int'(d) > LIMIT) e_err = 1'b1;
               else ref_sp = int'(d);
    endcase
    if (e_err && ref_errs < 255) ref_errs++;
    txn(op, d, dly, g_err, g_data, g_mcyc, g_addr, g_we, g_wd, g_lat);
    check("m_err", 32'(g_err), 32'(e_err));
    check("m_data", 32'(g_data), 32'(e_data));
    check("m_sp", 32'(sp_o), 32'(ref_sp));
    check("m_errcnt", 32'(err_count_o), 32'(ref_errs));
    check("m_mem_cycles", 32'(g_mcyc), e_mem ? 32'(dly + 1) : 32'd0);
    check("m_latency", 32'(g_lat), e_mem ? 32'(dly + 2) : 32'd1);
    if (e_mem) begin
      check("m_addr", 32'(g_addr), 32'(e_addr));
      check("m_we", 32'(g_we), 32'(e_we));
      if (e_we) check("m_wdata", 32'(g_wd), 32'(e_wd));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] d;
    int          dly;
    logic        err;
    logic [15:0] data;
    logic [15:0] sp;
    int          mcyc;
    logic [15:0] addr;
    logic        we;
    logic [15:0] wd;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic g_err, g_we;
    logic [15:0] g_data, g_addr, g_wd;
    int g_mcyc, g_lat, exp_errs;

    //          op    data      dly err  rsp_data  sp        mcyc addr      we    wdata
    vt[0]  = '{PUSH, 16'hABCD, 2, 1'b0, 16'h0000, 16'h2801, 3, 16'h2800, 1'b1, 16'hABCD};
    vt[1]  = '{POP,  16'h0000, 0, 1'b0, 16'hABCD, 16'h2800, 1, 16'h2800, 1'b0, 16'h0000};
    vt[2]  = '{POP,  16'h0000, 0, 1'b1, 16'h0000, 16'h2800, 0, 16'h0000, 1'b0, 16'h0000};
    vt[3]  = '{LOAD, 16'h31FF, 0, 1'b0, 16'h0000, 16'h31FF, 0, 16'h0000, 1'b0, 16'h0000};
    vt[4]  = '{PUSH, 16'h1234, 1, 1'b0, 16'h0000, 16'h3200, 2, 16'h31FF, 1'b1, 16'h1234};
    vt[5]  = '{PUSH, 16'h5555, 0, 1'b1, 16'h0000, 16'h3200, 0, 16'h0000, 1'b0, 16'h0000};
    vt[6]  = '{LOAD, 16'h3300, 0, 1'b1, 16'h0000, 16'h3200, 0, 16'h0000, 1'b0, 16'h0000};
    vt[7]  = '{PEEK, 16'h0000, 1, 1'b0, 16'h1234, 16'h3200, 2, 16'h31FF, 1'b0, 16'h0000};
    vt[8]  = '{LOAD, 16'h2800, 0, 1'b0, 16'h0000, 16'h2800, 0, 16'h0000, 1'b0, 16'h0000};
    vt[9]  = '{PEEK, 16'h0000, 0, 1'b1, 16'h0000, 16'h2800, 0, 16'h0000, 1'b0, 16'h0000};
    vt[10] = '{LOAD, 16'h27FF, 0, 1'b1, 16'h0000, 16'h2800, 0, 16'h0000, 1'b0, 16'h0000};
    vt[11] = '{LOAD, 16'h3200, 0, 1'b0, 16'h0000, 16'h3200, 0, 16'h0000, 1'b0, 16'h0000};

    // Power-on reset held for a few cycles.
    repeat (2) @(negedge clk_i);
    check("por_ready", 32'(req_ready_o), 32'd0);
    check("por_sp", 32'(sp_o), 32'h2800);
    check("por_mem_req", 32'(mem_req_o), 32'd0);
    check("por_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("por_errcnt", 32'(err_count_o), 32'd0);
    reset_ni = 1'b1;
    #1 check("por_release_ready", 32'(req_ready_o), 32'd1);

    exp_errs = 0;
    for (int i = 0; i < 12; i++) begin
      txn(vt[i].op, vt[i].d, vt[i].dly, g_err, g_data, g_mcyc, g_addr, g_we, g_wd, g_lat);
      if (vt[i].err) exp_errs++;
      check($sformatf("v%0d_err", i), 32'(g_err), 32'(vt[i].err));
      check($sformatf("v%0d_data", i), 32'(g_data), 32'(vt[i].data));
      check($sformatf("v%0d_sp", i), 32'(sp_o), 32'(vt[i].sp));
      check($sformatf("v%0d_mem_cycles", i), 32'(g_mcyc), 32'(vt[i].mcyc));
      check($sformatf("v%0d_latency", i), 32'(g_lat), (vt[i].mcyc > 0) ? 32'(vt[i].mcyc + 1) : 32'd1);
      if (vt[i].mcyc > 0) begin
        check($sformatf("v%0d_addr", i), 32'(g_addr), 32'(vt[i].addr));
        check($sformatf("v%0d_we", i), 32'(g_we), 32'(vt[i].we));
        if (vt[i].we) check($sformatf("v%0d_wdata", i), 32'(g_wd), 32'(vt[i].wd));
      end
    end
    check("table_errcnt", 32'(err_count_o), 32'(exp_errs));

    // Reset asserted in the middle of a cycle with SP away from base.
    #2 reset_ni = 1'b0;
    #1;
    check("t1_sp", 32'(sp_o), 32'h2800);
    check("t1_mem_req", 32'(mem_req_o), 32'd0);
    check("t1_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("t1_ready", 32'(req_ready_o), 32'd0);
    check("t1_errcnt", 32'(err_count_o), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1 check("t1_release_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);

    // Randomized traffic against the model.
    ref_sp = BASE; ref_errs = 0;
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  op;
      logic [15:0] d;
      op = 2'($urandom_range(0, 3));
      d  = 16'($urandom);
      if (op == LOAD && $urandom_range(0, 3) != 0) d = 16'($urandom_range('h27FE, 'h3201));
      run_model(op, d, $urandom_range(0, 3));
    end

    // Error counter saturation: repeated POPs on an empty stack.
    run_model(LOAD, 16'h2800, 0);
    for (int n = 0; n < 260; n++) run_model(POP, 16'h0000, 0);
    check("err_saturated", 32'(err_count_o), 32'hFF);

    // Reset while a PUSH waits for mem_ack; the late ack must be ignored.
    run_model(LOAD, 16'h3000, 0);
    req_valid_i = 1'b1; req_op_i = PUSH; req_data_i = 16'h7777;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    check("t6_mem_req_held", 32'(mem_req_o), 32'd1);
    check("t6_addr", 32'(mem_addr_o), 32'h3000);
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    #1;
    check("t6_mem_req_drop", 32'(mem_req_o), 32'd0);
    check("t6_sp", 32'(sp_o), 32'h2800);
    check("t6_rsp_valid", 32'(rsp_valid_o), 32'd0);
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("t6_late_ack_mem_req", 32'(mem_req_o), 32'd0);
    check("t6_late_ack_rsp", 32'(rsp_valid_o), 32'd0);
    check("t6_late_ack_sp", 32'(sp_o), 32'h2800);
    check("t6_late_ack_errcnt", 32'(err_count_o), 32'd0);
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    ref_sp = BASE; ref_errs = 0;
    run_model(PUSH, 16'h4242, 1);
    run_model(POP, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
